// File: rtl/ws_pkg.sv
// Shared types and constants for the WS2811 pixel frame sequencer.
package ws_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        SCALE     = 3'd2,
        SEND      = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5
    } seqState_t;

    localparam int DEFAULT_UNITS    = 100;
    localparam int DEFAULT_COLORS   = 128;
    localparam int DEFAULT_PATTERNS = 4;

    localparam logic [7:0] BRIGHT_STEP  = 8'd16;
    localparam logic [7:0] BRIGHT_RESET = 8'd255;

    // Saturating brightness step; simultaneous up and down cancel out.
    function automatic logic [7:0] nextBrightness(input logic [7:0] cur,
                                                  input logic up,
                                                  input logic down);
        logic [7:0] res;
        res = cur;
        if (up && !down) begin
            res = (cur > (8'd255 - BRIGHT_STEP)) ? 8'd255 : cur + BRIGHT_STEP;
        end else if (down && !up) begin
            res = (cur < BRIGHT_STEP) ? 8'd0 : cur - BRIGHT_STEP;
        end
        return res;
    endfunction

endpackage

// File: rtl/rgb_brightness_scaler.sv
// Registered per-channel brightness scaler: out = (c * (brightness + 1)) >> 8.
module rgb_brightness_scaler
    import ws_pkg::*;
(
    input  logic        clkIN,
    input  logic        nResetIN,
    input  logic        enIN,
    input  logic [23:0] colourIN,
    input  logic [7:0]  brightIN,
    output logic [23:0] colourOUT
);

    function automatic logic [7:0] scaleChannel(input logic [7:0] c, input logic [7:0] b);
        return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
    endfunction

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            colourOUT <= 24'd0;
        end else if (enIN) begin
            colourOUT <= {scaleChannel(colourIN[23:16], brightIN),
                          scaleChannel(colourIN[15:8],  brightIN),
                          scaleChannel(colourIN[7:0],   brightIN)};
        end
    end

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Walks one frame of LEDs: fetch colour from ROM, scale by brightness, hand to the WS2811 transmitter.
module pixel_frame_sequencer
    import ws_pkg::*;
#(
    parameter int UNITS_NUMBER          = DEFAULT_UNITS,
    parameter int PATTERN_COLORS_NUMBER = DEFAULT_COLORS,
    parameter int PATTERNS_NUMBER       = DEFAULT_PATTERNS,
    parameter int ROM_LATENCY           = 1
)(
    input  logic        clkIN,
    input  logic        nResetIN,
    input  logic        frameTickIN,
    input  logic        patternNextIN,
    input  logic        patternPrevIN,
    input  logic        brightUpIN,
    input  logic        brightDownIN,
    output logic [$clog2(PATTERNS_NUMBER)+$clog2(PATTERN_COLORS_NUMBER)-1:0] romAddrOUT,
    input  logic [23:0] romDataIN,
    output logic        txStartOUT,
    output logic [23:0] txDataOUT,
    input  logic        txBusyIN,
    output logic        frameActiveOUT,
    output logic        frameDropOUT,
    output logic [2:0]  stateDbgOUT
);

    localparam int PW = $clog2(PATTERNS_NUMBER);
    localparam int CW = $clog2(PATTERN_COLORS_NUMBER);
    localparam int UW = (UNITS_NUMBER > 1) ? $clog2(UNITS_NUMBER) : 1;
    localparam int LW = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;

    seqState_t state, nextState;

    logic [UW-1:0] unit;
    logic [CW-1:0] shift;
    logic [CW-1:0] colourIndex;
    logic [PW-1:0] pattern;
    logic [PW-1:0] latchedPattern;
    logic [7:0]    brightness;
    logic [LW-1:0] latCnt;
    logic [23:0]   romWord;
    logic          lastUnit;
    logic          romReady;

    // Power-of-two colour count, so truncation gives the modulo wrap.
    assign colourIndex = CW'(unit) + shift;
    assign lastUnit    = (unit == UW'(UNITS_NUMBER - 1));
    assign romReady    = (latCnt == LW'(ROM_LATENCY));

    assign romAddrOUT     = {latchedPattern, colourIndex};
    assign txStartOUT     = (state == SEND);
    assign frameActiveOUT = (state != IDLE);
    assign frameDropOUT   = frameTickIN && (state != IDLE);
    assign stateDbgOUT    = state;

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (frameTickIN) nextState = FETCH;
            FETCH:     if (romReady) nextState = SCALE;
            SCALE:     nextState = SEND;
            SEND:      nextState = WAIT_ACK;
            WAIT_ACK:  if (txBusyIN) nextState = WAIT_DONE;
            WAIT_DONE: if (!txBusyIN) nextState = lastUnit ? IDLE : FETCH;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            unit           <= '0;
            shift          <= '0;
            latchedPattern <= '0;
            latCnt         <= '0;
            romWord        <= 24'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frameTickIN) begin
                        latchedPattern <= pattern;
                        unit           <= '0;
                        shift          <= shift + CW'(1);
                        latCnt         <= '0;
                    end
                end
                FETCH: begin
                    if (romReady) begin
                        romWord <= romDataIN;
                    end else begin
                        latCnt <= latCnt + LW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!txBusyIN) begin
                        latCnt <= '0;
                        if (!lastUnit) begin
                            unit <= unit + UW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pattern and brightness track the buttons continuously; a frame only sees them when latched/scaled.
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            pattern    <= '0;
            brightness <= BRIGHT_RESET;
        end else begin
            if (patternNextIN && !patternPrevIN) begin
                pattern <= pattern + PW'(1);
            end else if (patternPrevIN && !patternNextIN) begin
                pattern <= pattern - PW'(1);
            end
            brightness <= nextBrightness(brightness, brightUpIN, brightDownIN);
        end
    end

    rgb_brightness_scaler scaler (
        .clkIN     (clkIN),
        .nResetIN  (nResetIN),
        .enIN      (state == SCALE),
        .colourIN  (romWord),
        .brightIN  (brightness),
        .colourOUT (txDataOUT)
    );

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench: full frames against a ROM and busy-transmitter model, plus a small-geometry instance for wrap and ROM latency.
module tb_pixel_frame_sequencer;
    import ws_pkg::*;

    localparam logic [23:0] ROM_CONST = 24'h80FF40;

    logic        clkIN = 1'b0;
    logic        nResetIN = 1'b0;
    logic        frameTickIN = 1'b0, patternNextIN = 1'b0, patternPrevIN = 1'b0;
    logic        brightUpIN = 1'b0, brightDownIN = 1'b0;
    logic [8:0]  romAddrOUT;
    logic [23:0] romDataIN = 24'd0;
    logic        txStartOUT, txBusyIN, frameActiveOUT, frameDropOUT;
    logic [23:0] txDataOUT;
    logic [2:0]  stateDbgOUT;

    logic        frameTick2 = 1'b0;
    logic [3:0]  romAddr2;
    logic [23:0] romData2 = 24'd0, romPipe2 = 24'd0;
    logic        txStart2, txBusy2, frameActive2, frameDrop2;
    logic [23:0] txData2;
    logic [2:0]  stateDbg2;

    int totalChecks = 0;
    int badChecks = 0;
    int busyLen = 30;
    int busyCnt = 0, busyCnt2 = 0;
    int startCount = 0, dropCount = 0, startCount2 = 0;
    int expShift = 0, expPattern = 0;
    logic romMode = 1'b0;

    logic [32:0] exp_q[$];
    logic [27:0] exp2_q[$];

    always #5 clkIN = ~clkIN;

    pixel_frame_sequencer #(
        .UNITS_NUMBER(100), .PATTERN_COLORS_NUMBER(128), .PATTERNS_NUMBER(4), .ROM_LATENCY(1)
    ) dut (
        .clkIN(clkIN), .nResetIN(nResetIN), .frameTickIN(frameTickIN),
        .patternNextIN(patternNextIN), .patternPrevIN(patternPrevIN),
        .brightUpIN(brightUpIN), .brightDownIN(brightDownIN),
        .romAddrOUT(romAddrOUT), .romDataIN(romDataIN),
        .txStartOUT(txStartOUT), .txDataOUT(txDataOUT), .txBusyIN(txBusyIN),
        .frameActiveOUT(frameActiveOUT), .frameDropOUT(frameDropOUT), .stateDbgOUT(stateDbgOUT)
    );

    pixel_frame_sequencer #(
        .UNITS_NUMBER(12), .PATTERN_COLORS_NUMBER(8), .PATTERNS_NUMBER(2), .ROM_LATENCY(2)
    ) dut2 (
        .clkIN(clkIN), .nResetIN(nResetIN), .frameTickIN(frameTick2),
        .patternNextIN(1'b0), .patternPrevIN(1'b0),
        .brightUpIN(1'b0), .brightDownIN(1'b0),
        .romAddrOUT(romAddr2), .romDataIN(romData2),
        .txStartOUT(txStart2), .txDataOUT(txData2), .txBusyIN(txBusy2),
        .frameActiveOUT(frameActive2), .frameDropOUT(frameDrop2), .stateDbgOUT(stateDbg2)
    );

    function automatic logic [23:0] romFn(input logic [8:0] a);
        return {a[7:0], 7'd0, a[8], ~a[7:0]};
    endfunction

    function automatic logic [23:0] romFn2(input logic [3:0] a);
        return {4'hA, a, 8'h5A, 4'h0, ~a};
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ROM and transmitter models
    always @(posedge clkIN) begin
        romDataIN <= romMode ? ROM_CONST : romFn(romAddrOUT);
        romPipe2  <= romFn2(romAddr2);
        romData2  <= romPipe2;
        if (txStartOUT) busyCnt <= busyLen;
        else if (busyCnt != 0) busyCnt <= busyCnt - 1;
        if (txStart2) busyCnt2 <= 3;
        else if (busyCnt2 != 0) busyCnt2 <= busyCnt2 - 1;
    end
    assign txBusyIN = (busyCnt != 0);
    assign txBusy2  = (busyCnt2 != 0);

    // Scoreboard monitors
    always @(negedge clkIN) begin
        logic [32:0] e;
        logic [27:0] e2;
        if (nResetIN) begin
            if (frameDropOUT) dropCount++;
            if (txStartOUT) begin
                startCount++;
                if (exp_q.size() == 0) begin
                    checkValue("unexpected_start", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkValue("tx_addr", 32'(romAddrOUT), 32'(e[32:24]));
                    checkValue("tx_data", 32'(txDataOUT), 32'(e[23:0]));
                end
            end
            if (txStart2) begin
                startCount2++;
                if (exp2_q.size() == 0) begin
                    checkValue("unexpected_start2", 32'd1, 32'd0);
                end else begin
                    e2 = exp2_q.pop_front();
                    checkValue("tx2_addr", 32'(romAddr2), 32'(e2[27:24]));
                    checkValue("tx2_data", 32'(txData2), 32'(e2[23:0]));
                end
            end
        end
    end

    task automatic pushFrame(input logic [23:0] constExp);
        logic [8:0] a;
        expShift = (expShift + 1) % 128;
        for (int u = 0; u < 100; u++) begin
            a = 9'(expPattern * 128 + ((u + expShift) % 128));
            exp_q.push_back({a, romMode ? constExp : romFn(a)});
        end
    endtask

    task automatic runFrame(input int dropAt, input int patAt, input logic patNext,
                            input logic patPrev, input logic [23:0] constExp, input int budget);
        int cyc;
        pushFrame(constExp);
        startCount = 0;
        dropCount = 0;
        @(posedge clkIN); #1 frameTickIN = 1'b1;
        @(posedge clkIN); #1 frameTickIN = 1'b0;
        cyc = 0;
        while (frameActiveOUT && cyc < budget) begin
            @(posedge clkIN); #1;
            cyc++;
            frameTickIN   = (cyc == dropAt);
            patternNextIN = (cyc == patAt) && patNext;
            patternPrevIN = (cyc == patAt) && patPrev;
            if (cyc == patAt && patNext && !patPrev) expPattern = (expPattern + 1) % 4;
            if (cyc == patAt && patPrev && !patNext) expPattern = (expPattern + 3) % 4;
        end
        frameTickIN = 1'b0;
        patternNextIN = 1'b0;
        patternPrevIN = 1'b0;
        checkValue("frame_in_budget", 32'(cyc < budget), 32'd1);
        checkValue("start_count", 32'(startCount), 32'd100);
        checkValue("exp_q_drained", 32'(exp_q.size()), 32'd0);
        checkValue("drop_count", 32'(dropCount), (dropAt > 0) ? 32'd1 : 32'd0);
        checkValue("busy_low_at_end", 32'(txBusyIN), 32'd0);
        exp_q.delete();
    endtask

    task automatic stepBright(input int n, input logic up, input logic down);
        for (int i = 0; i < n; i++) begin
            @(posedge clkIN); #1 brightUpIN = up; brightDownIN = down;
            @(posedge clkIN); #1 brightUpIN = 1'b0; brightDownIN = 1'b0;
        end
    endtask

    task automatic checkOutputsZero(input string phase);
        checkValue({phase, "_romAddr"}, 32'(romAddrOUT), 32'd0);
        checkValue({phase, "_txStart"}, 32'(txStartOUT), 32'd0);
        checkValue({phase, "_txData"}, 32'(txDataOUT), 32'd0);
        checkValue({phase, "_frameActive"}, 32'(frameActiveOUT), 32'd0);
        checkValue({phase, "_frameDrop"}, 32'(frameDropOUT), 32'd0);
        checkValue({phase, "_state"}, 32'(stateDbgOUT), 32'(IDLE));
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clkIN);
        #1 checkOutputsZero("reset");
        nResetIN = 1'b1;

        // Shift 1, pattern 0, with an ignored tick mid-frame
        busyLen = 30;
        runFrame(300, 0, 1'b0, 1'b0, 24'd0, 6000);
        // Prev during frame: this frame stays on pattern 0, the next uses pattern 3
        runFrame(0, 500, 1'b0, 1'b1, 24'd0, 6000);
        // Next and prev together leave the pattern alone
        runFrame(0, 200, 1'b1, 1'b1, 24'd0, 6000);
        @(posedge clkIN); #1 patternNextIN = 1'b1;
        expPattern = (expPattern + 1) % 4;
        @(posedge clkIN); #1 patternNextIN = 1'b0;

        // Brightness sweep on a constant ROM word
        busyLen = 2;
        romMode = 1'b1;
        runFrame(0, 0, 1'b0, 1'b0, 24'h80FF40, 5000);
        stepBright(8, 1'b0, 1'b1);
        stepBright(1, 1'b1, 1'b1);
        runFrame(0, 0, 1'b0, 1'b0, 24'h407F20, 5000);
        stepBright(9, 1'b0, 1'b1);
        runFrame(0, 0, 1'b0, 1'b0, 24'h000000, 5000);
        stepBright(15, 1'b1, 1'b0);
        runFrame(0, 0, 1'b0, 1'b0, 24'h78F03C, 5000);
        stepBright(1, 1'b1, 1'b0);
        runFrame(0, 0, 1'b0, 1'b0, 24'h80FF40, 5000);

        // Reset while waiting on the transmitter at unit 50
        busyLen = 30;
        romMode = 1'b0;
        pushFrame(24'd0);
        startCount = 0;
        @(posedge clkIN); #1 frameTickIN = 1'b1;
        @(posedge clkIN); #1 frameTickIN = 1'b0;
        cyc = 0;
        while (!(startCount == 51 && stateDbgOUT == WAIT_DONE) && cyc < 4000) begin
            @(posedge clkIN); #1;
            cyc++;
        end
        checkValue("reach_unit50", 32'(cyc < 4000), 32'd1);
        nResetIN = 1'b0;
        #1 checkOutputsZero("midframe_reset");
        exp_q.delete();
        cyc = 0;
        while (txBusyIN && cyc < 100) begin
            @(posedge clkIN); #1;
            cyc++;
        end
        @(posedge clkIN); #1 nResetIN = 1'b1;
        expShift = 0;
        expPattern = 0;
        runFrame(0, 0, 1'b0, 1'b0, 24'd0, 6000);

        // Small geometry: colour index wraps at 8, shift register wraps too, ROM latency 2
        for (int s = 1; s <= 9; s++) begin
            for (int u = 0; u < 12; u++) begin
                logic [3:0] a2;
                a2 = 4'((u + s) % 8);
                exp2_q.push_back({a2, romFn2(a2)});
            end
            startCount2 = 0;
            @(posedge clkIN); #1 frameTick2 = 1'b1;
            @(posedge clkIN); #1 frameTick2 = 1'b0;
            cyc = 0;
            while (frameActive2 && cyc < 400) begin
                @(posedge clkIN); #1;
                cyc++;
            end
            checkValue("small_in_budget", 32'(cyc < 400), 32'd1);
            checkValue("small_start_count", 32'(startCount2), 32'd12);
            checkValue("small_q_drained", 32'(exp2_q.size()), 32'd0);
            exp2_q.delete();
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
